// File: rtl/nanosoc_dma_fifo_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nanosoc_dma_fifo_target_pkg
// Description : Register map, bit positions and AHB encodings for the DMA
//               FIFO target.
// Revision    : 1.0
// ============================================================================
package nanosoc_dma_fifo_target_pkg;

    localparam logic [3:0] c_OFS_DATA   = 4'h0;
    localparam logic [3:0] c_OFS_STATUS = 4'h4;
    localparam logic [3:0] c_OFS_CTRL   = 4'h8;
    localparam logic [3:0] c_OFS_CLEAR  = 4'hC;

    // Word index decoded from HADDR[3:2]
    localparam logic [1:0] c_IDX_DATA   = c_OFS_DATA[3:2];
    localparam logic [1:0] c_IDX_STATUS = c_OFS_STATUS[3:2];
    localparam logic [1:0] c_IDX_CTRL   = c_OFS_CTRL[3:2];
    localparam logic [1:0] c_IDX_CLEAR  = c_OFS_CLEAR[3:2];

    localparam int c_STAT_EMPTY = 8;
    localparam int c_STAT_FULL  = 9;
    localparam int c_STAT_OVF   = 10;
    localparam int c_STAT_UDF   = 11;
    localparam int c_STAT_DONE0 = 12;
    localparam int c_STAT_DONE1 = 13;

    localparam int c_CTRL_REQ0 = 0;
    localparam int c_CTRL_REQ1 = 1;
    localparam int c_CTRL_IRQ0 = 4;
    localparam int c_CTRL_IRQ1 = 5;

    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] c_HSIZE_WORD    = 3'b010;

    typedef enum logic [0:0] {
        ST_OKAY = 1'b0,
        ST_ERR2 = 1'b1
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/nanosoc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nanosoc_sync_fifo
// Description : Single-clock word FIFO with look-ahead full/empty flags.
// Revision    : 1.0
// ============================================================================
module nanosoc_sync_fifo #(
    parameter int FIFO_AW = 3,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic [FIFO_AW:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_full_next,
    output logic              o_empty_next
);

    localparam int               c_DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [FIFO_AW:0]   w_count_next;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    assign o_full_next  = (w_count_next == c_FULL_CNT);
    assign o_empty_next = (w_count_next == '0);
    assign o_count      = r_count;
    assign o_rdata      = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    // Storage carries no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/nanosoc_dma_fifo_target.sv
`default_nettype none
// ============================================================================
// Module      : nanosoc_dma_fifo_target
// Description : AHB-Lite DMA loopback target: word FIFO plus DMA request,
//               done and interrupt handling.
// Revision    : 1.0
// ============================================================================
module nanosoc_dma_fifo_target
    import nanosoc_dma_fifo_target_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int FIFO_AW = 3
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA,
    output logic [1:0]        DMA_REQ,
    input  logic [1:0]        DMA_DONE,
    output logic              IRQ
);

    logic        r_valid;
    logic        r_write;
    logic [1:0]  r_idx;
    logic [2:0]  r_size;
    resp_state_t r_state;
    resp_state_t w_state_next;

    logic [1:0]  r_req_en;
    logic [1:0]  r_irq_en;
    logic        r_ovf;
    logic        r_udf;
    logic [1:0]  r_done;

    logic [1:0]  w_req_en_next;
    logic [1:0]  w_irq_en_next;
    logic        w_ovf_next;
    logic        w_udf_next;
    logic [1:0]  w_done_next;

    logic [DATA_W-1:0] w_head;
    logic [FIFO_AW:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_full_next;
    logic              w_empty_next;

    logic w_addr_ph;
    logic w_live;
    logic w_is_data;
    logic w_size_err;
    logic w_ovf_err;
    logic w_udf_err;
    logic w_err;
    logic w_ok;
    logic w_push;
    logic w_pop;
    logic w_ctrl_wr;
    logic w_clr_wr;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_ctrl_rd;

    assign w_addr_ph = HSEL & HREADY &
                       ((HTRANS == c_HTRANS_NONSEQ) | (HTRANS == c_HTRANS_SEQ));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_size  <= '0;
        end else if (HREADY) begin
            r_valid <= w_addr_ph;
            r_write <= HWRITE;
            r_idx   <= HADDR[3:2];
            r_size  <= HSIZE;
        end
    end

    // Data phase is only "live" in the OKAY state; the second error cycle
    // still holds the stale phase but must not act on it again.
    assign w_live     = r_valid & (r_state == ST_OKAY);
    assign w_is_data  = (r_idx == c_IDX_DATA);
    assign w_size_err = (r_size != c_HSIZE_WORD);
    assign w_ovf_err  = ~w_size_err & w_is_data &  r_write & w_full;
    assign w_udf_err  = ~w_size_err & w_is_data & ~r_write & w_empty;
    assign w_err      = w_live & (w_size_err | w_ovf_err | w_udf_err);
    assign w_ok       = w_live & ~w_err;
    assign w_push     = w_ok &  r_write & w_is_data;
    assign w_pop      = w_ok & ~r_write & w_is_data;
    assign w_ctrl_wr  = w_ok & r_write & (r_idx == c_IDX_CTRL);
    assign w_clr_wr   = w_ok & r_write & (r_idx == c_IDX_CLEAR);

    always_comb begin
        w_state_next = r_state;
        HREADYOUT    = 1'b1;
        HRESP        = 1'b0;
        case (r_state)
            ST_OKAY: begin
                if (w_err) begin
                    HREADYOUT    = 1'b0;
                    HRESP        = 1'b1;
                    w_state_next = ST_ERR2;
                end
            end
            ST_ERR2: begin
                HRESP        = 1'b1;
                w_state_next = ST_OKAY;
            end
            default: w_state_next = ST_OKAY;
        endcase
    end

    // DONE overrides a same-cycle CTRL write and a same-cycle CLEAR
    always_comb begin
        w_req_en_next = r_req_en;
        w_irq_en_next = r_irq_en;
        if (w_ctrl_wr) begin
            w_req_en_next = {HWDATA[c_CTRL_REQ1], HWDATA[c_CTRL_REQ0]};
            w_irq_en_next = {HWDATA[c_CTRL_IRQ1], HWDATA[c_CTRL_IRQ0]};
        end
        w_req_en_next = w_req_en_next & ~DMA_DONE;

        w_ovf_next  = (r_ovf & ~(w_clr_wr & HWDATA[c_STAT_OVF])) | (w_err & w_ovf_err);
        w_udf_next  = (r_udf & ~(w_clr_wr & HWDATA[c_STAT_UDF])) | (w_err & w_udf_err);
        w_done_next = r_done;
        if (w_clr_wr) begin
            w_done_next = r_done & ~{HWDATA[c_STAT_DONE1], HWDATA[c_STAT_DONE0]};
        end
        w_done_next = w_done_next | DMA_DONE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= ST_OKAY;
            r_req_en <= '0;
            r_irq_en <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_done   <= '0;
            DMA_REQ  <= '0;
            IRQ      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_req_en <= w_req_en_next;
            r_irq_en <= w_irq_en_next;
            r_ovf    <= w_ovf_next;
            r_udf    <= w_udf_next;
            r_done   <= w_done_next;
            DMA_REQ  <= {w_req_en_next[1] & ~w_empty_next,
                         w_req_en_next[0] & ~w_full_next};
            IRQ      <= |(r_done & r_irq_en);
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[FIFO_AW:0]      = w_count;
        w_status[c_STAT_EMPTY]   = w_empty;
        w_status[c_STAT_FULL]    = w_full;
        w_status[c_STAT_OVF]     = r_ovf;
        w_status[c_STAT_UDF]     = r_udf;
        w_status[c_STAT_DONE0]   = r_done[0];
        w_status[c_STAT_DONE1]   = r_done[1];

        w_ctrl_rd                = '0;
        w_ctrl_rd[c_CTRL_REQ0]   = r_req_en[0];
        w_ctrl_rd[c_CTRL_REQ1]   = r_req_en[1];
        w_ctrl_rd[c_CTRL_IRQ0]   = r_irq_en[0];
        w_ctrl_rd[c_CTRL_IRQ1]   = r_irq_en[1];

        HRDATA = '0;
        if (w_ok & ~r_write) begin
            case (r_idx)
                c_IDX_DATA:   HRDATA = w_head;
                c_IDX_STATUS: HRDATA = w_status;
                c_IDX_CTRL:   HRDATA = w_ctrl_rd;
                default:      HRDATA = '0;
            endcase
        end
    end

    nanosoc_sync_fifo #(
        .FIFO_AW (FIFO_AW),
        .DATA_W  (DATA_W)
    ) u_fifo (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_wdata      (HWDATA),
        .o_rdata      (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_full_next  (w_full_next),
        .o_empty_next (w_empty_next)
    );

    logic w_unused;
    assign w_unused = &{1'b0, HADDR, HWDATA};

endmodule
`default_nettype wire

// File: tb/tb_nanosoc_dma_fifo_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_nanosoc_dma_fifo_target
// Description : Directed self-checking bench for the DMA FIFO target.
// Revision    : 1.0
// ============================================================================
module tb_nanosoc_dma_fifo_target;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [11:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [1:0]  DMA_REQ;
    logic [1:0]  DMA_DONE = '0;
    logic        IRQ;

    int tests = 0;
    int fails = 0;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    nanosoc_dma_fifo_target #(
        .ADDR_W  (12),
        .DATA_W  (32),
        .FIFO_AW (3)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .DMA_REQ   (DMA_REQ),
        .DMA_DONE  (DMA_DONE),
        .IRQ       (IRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer. resp: 0 = OKAY, 1 = well-formed
    // two-cycle ERROR, 2 = anything else. Entered/left #1 after a rising edge.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [2:0] sz, output logic [31:0] rd, output int resp);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = sz;
        @(posedge HCLK); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = wd;
        rd     = HRDATA;
        if (HREADYOUT === 1'b1 && HRESP === 1'b0) begin
            resp = 0;
            @(posedge HCLK); #1;
        end else if (HREADYOUT === 1'b0 && HRESP === 1'b1) begin
            @(posedge HCLK); #1;
            resp = (HREADYOUT === 1'b1 && HRESP === 1'b1) ? 1 : 2;
            @(posedge HCLK); #1;
        end else begin
            resp = 2;
            @(posedge HCLK); #1;
        end
    endtask

    task automatic wr_reg(input string tag, input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        int          resp;
        xfer(1'b1, addr, wd, 3'b010, rd, resp);
        check({tag, ".resp"}, 32'(resp), 32'd0);
    endtask

    task automatic rd_reg(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        int          resp;
        xfer(1'b0, addr, 32'h0, 3'b010, rd, resp);
        check({tag, ".resp"}, 32'(resp), 32'd0);
        check(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int          resp;

        // Reset
        repeat (3) @(posedge HCLK);
        #1;
        check("rst.hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst.hresp",     {31'd0, HRESP},     32'd0);
        check("rst.hrdata",    HRDATA,             32'd0);
        check("rst.dma_req",   {30'd0, DMA_REQ},   32'd0);
        check("rst.irq",       {31'd0, IRQ},       32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd_reg("rst.status", 12'h004, 32'h0000_0100);

        // Enable both requests and fill the FIFO
        wr_reg("ctrl.wr3", 12'h008, 32'h3);
        check("ctrl.req", {30'd0, DMA_REQ}, 32'b01);
        for (int i = 0; i < 8; i++) begin
            wr_reg($sformatf("fill%0d", i), 12'h000, 32'hA0 + 32'(i));
            check($sformatf("fill%0d.req", i), {30'd0, DMA_REQ}, (i < 7) ? 32'b11 : 32'b10);
        end
        rd_reg("full.status", 12'h004, 32'h0000_0208);

        // Overflow
        xfer(1'b1, 12'h000, 32'hFF, 3'b010, rd, resp);
        check("ovf.resp", 32'(resp), 32'd1);
        rd_reg("ovf.status", 12'h004, 32'h0000_0608);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            rd_reg($sformatf("drain%0d", i), 12'h000, 32'hA0 + 32'(i));
        end
        check("drain.req", {30'd0, DMA_REQ}, 32'b01);

        // Underflow
        xfer(1'b0, 12'h000, 32'h0, 3'b010, rd, resp);
        check("udf.resp", 32'(resp), 32'd1);
        check("udf.hrdata", rd, 32'd0);
        rd_reg("udf.status", 12'h004, 32'h0000_0D00);
        wr_reg("clr.wr", 12'h00C, 32'h0000_0C00);
        rd_reg("clr.status", 12'h004, 32'h0000_0100);

        // DONE on channel 0 with interrupt enabled
        wr_reg("ctrl.wr31", 12'h008, 32'h31);
        check("ctrl31.req", {30'd0, DMA_REQ}, 32'b01);
        DMA_DONE = 2'b01;
        @(posedge HCLK); #1;
        DMA_DONE = 2'b00;
        check("done0.req", {30'd0, DMA_REQ}, 32'b00);
        check("done0.irq_early", {31'd0, IRQ}, 32'd0);
        @(posedge HCLK); #1;
        check("done0.irq", {31'd0, IRQ}, 32'd1);
        rd_reg("done0.ctrl", 12'h008, 32'h30);
        rd_reg("done0.status", 12'h004, 32'h0000_1100);
        wr_reg("clr.done0", 12'h00C, 32'h0000_1000);
        @(posedge HCLK); #1;
        check("clr.irq", {31'd0, IRQ}, 32'd0);

        // Both DONE bits together
        wr_reg("ctrl.wr33", 12'h008, 32'h33);
        DMA_DONE = 2'b11;
        @(posedge HCLK); #1;
        DMA_DONE = 2'b00;
        check("done11.req", {30'd0, DMA_REQ}, 32'b00);
        rd_reg("done11.ctrl", 12'h008, 32'h30);
        rd_reg("done11.status", 12'h004, 32'h0000_3100);
        wr_reg("clr.done11", 12'h00C, 32'h0000_3000);
        rd_reg("clr11.status", 12'h004, 32'h0000_0100);

        // Size error on DATA: no push, no sticky
        xfer(1'b1, 12'h000, 32'h55, 3'b000, rd, resp);
        check("size.resp", 32'(resp), 32'd1);
        rd_reg("size.status", 12'h004, 32'h0000_0100);

        // Reset during the first ERROR cycle
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 12'h000;
        HWRITE = 1'b1;
        HSIZE  = 3'b000;
        @(posedge HCLK); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        check("rsterr.hreadyout_pre", {31'd0, HREADYOUT}, 32'd0);
        check("rsterr.hresp_pre",     {31'd0, HRESP},     32'd1);
        HRESETn = 1'b0;
        #1;
        check("rsterr.hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rsterr.hresp",     {31'd0, HRESP},     32'd0);
        check("rsterr.irq",       {31'd0, IRQ},       32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        HSIZE   = 3'b010;
        @(posedge HCLK); #1;
        rd_reg("rsterr.ctrl", 12'h008, 32'h0);
        rd_reg("rsterr.status", 12'h004, 32'h0000_0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
